adder_err_eval_seq: RTL and testbench
=====================================

Name: adder_err_eval_seq

Overview:
- Controller that exhaustively sequences an external exact adder and an external approximate adder through every operand pair.
- Both adders share the operand bus; their sums return combinationally in the same cycle.
- Accumulates error metrics: mismatch count, maximum absolute error, sum of absolute errors, and the first operand pair that reached the maximum.
- Sits between the combinational adder netlists under evaluation and the error-evaluation harness, which reads results after done.

Parameters:
- WIDTH, 8, operand width of each adder input.
- SUM_W, WIDTH+1, derived; adder sum width.
- CNT_W, 2*WIDTH+1, derived; error-count width, holds up to 2^(2*WIDTH).
- ACC_W, 3*WIDTH+1, derived; sum-of-absolute-error width, cannot overflow.

Ports:
- clk, input, 1, single clock; all state is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a sweep; sampled only in IDLE or DONE.
- abort, input, 1, abandon the sweep from any state.
- op_a, output, WIDTH, operand A driven to both adders.
- op_b, output, WIDTH, operand B driven to both adders.
- exact_sum, input, SUM_W, exact adder result for the current op_a/op_b.
- approx_sum, input, SUM_W, approximate adder result for the current op_a/op_b.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, high while in DONE.
- err_count, output, CNT_W, number of vectors with exact_sum != approx_sum.
- max_abs_err, output, SUM_W, maximum |exact_sum - approx_sum|.
- sum_abs_err, output, ACC_W, sum of |exact_sum - approx_sum| over all vectors.
- worst_a, output, WIDTH, op_a of the first vector reaching max_abs_err.
- worst_b, output, WIDTH, op_b of the first vector reaching max_abs_err.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - Vector counter, op_a, op_b, all metrics, worst_a and worst_b go to 0.
  - busy=0, done=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, start=1, abort=0:
  - Next state RUN; counter=0.
  - Metrics, worst_a/worst_b and stage-1 valid are cleared.
- RUN:
  - {op_a,op_b} = counter; op_a is the upper half.
  - Each cycle, stage 1 registers abs diff, mismatch flag, op_a, op_b and valid=1.
  - Counter increments each cycle.
  - When counter == all-ones, next state is DRAIN and the counter wraps to 0.
- DRAIN:
  - op_a/op_b = 0; stage 1 loads valid=0.
  - Stage 2 accumulates the final vector.
  - Next state DONE.
- Stage 2 accumulates whenever stage-1 valid=1:
  - err_count += mismatch.
  - sum_abs_err += diff.
  - If diff > max_abs_err (strictly greater): update max_abs_err, worst_a, worst_b. Ties keep the earlier vector.
- Abs diff: zero-extend both sums, subtract, take magnitude; SUM_W bits suffice.
- Timing: start sampled at edge 0.
  - RUN occupies edges 1..2^(2W).
  - DRAIN ends at edge 2^(2W)+1.
  - done rises after that edge: for WIDTH=8, done is seen from cycle 65538.
- DONE: done=1 and metrics are held stable until start or abort.
- op_a/op_b are held at 0 in IDLE and DONE.
- start while busy is ignored.
- abort=1 in any state:
  - Next state IDLE; busy=0, done=0, op_a/op_b=0, stage-1 valid=0.
  - Metrics keep their partial values until the next start.
- abort and start in the same cycle: abort wins.
- rst_n low mid-sweep: immediate clear as for reset; no result is retained.

Decomposition:
- Shared package adder_eval_pkg holds:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Width-derivation functions for SUM_W, CNT_W, ACC_W.
- One sub-module, adder_err_diff:
  - Combinational, parameterised by SUM_W.
  - Outputs abs diff and mismatch flag.
  - Instantiated once ahead of stage 1.

Test Plan:
- WIDTH=8, approx_sum tied to exact model, start pulse -> busy cycles 1..65537, done from cycle 65538; err_count=0, max_abs_err=0, sum_abs_err=0, worst_a=worst_b=0.
- WIDTH=8, approx_sum = exact with LSB forced 0 -> err_count=32768, max_abs_err=1, sum_abs_err=32768, worst_a=0, worst_b=1.
- WIDTH=2, approx_sum = exact with MSB forced 0 -> err_count=6, max_abs_err=4, sum_abs_err=24, worst_a=1, worst_b=3.
- WIDTH=2, abort at counter=5 -> IDLE next edge, busy=0, done=0, op_a=op_b=0; a following start gives full correct results as above.
- WIDTH=2, start re-pulsed during RUN, and start+abort together in IDLE -> re-pulse ignored (done still at cycle 18); start+abort leaves state IDLE.
- WIDTH=2, rst_n low at counter=9 -> all outputs 0 immediately without a clock edge; after release, IDLE until start.

Source files
------------

// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the adder error evaluator.
// Imported by the sequencer top.
package adder_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int acc_w(input int w);
        return 3 * w + 1;
    endfunction

endpackage

// File: rtl/adder_err_diff.sv
// Magnitude of the difference between the exact and approximate sums,
// plus a mismatch flag.
module adder_err_diff #(
    parameter int SUM_W = 9
) (
    input  logic [SUM_W-1:0] exact_sum,
    input  logic [SUM_W-1:0] approx_sum,
    output logic [SUM_W-1:0] abs_diff,
    output logic             mismatch
);

    always_comb begin
        if (exact_sum >= approx_sum) begin
            abs_diff = exact_sum - approx_sum;
        end else begin
            abs_diff = approx_sum - exact_sum;
        end
        mismatch = (exact_sum != approx_sum);
    end

endmodule

// File: rtl/adder_err_eval_seq.sv
// Sweeps every operand pair through an exact and an approximate adder
// and accumulates error metrics over a two-stage pipeline.
module adder_err_eval_seq
    import adder_eval_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SUM_W = sum_w(WIDTH),
    parameter int CNT_W = cnt_w(WIDTH),
    parameter int ACC_W = acc_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [SUM_W-1:0] exact_sum,
    input  logic [SUM_W-1:0] approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] max_abs_err,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH-1:0] worst_a,
    output logic [WIDTH-1:0] worst_b
);

    localparam int VW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [VW-1:0]    cnt_q, cnt_d;
    logic [VW-1:0]    op_vec;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_mis_q, s1_mis_d;
    logic [SUM_W-1:0] s1_diff_q, s1_diff_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;

    logic [CNT_W-1:0] err_q, err_d;
    logic [SUM_W-1:0] max_q, max_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wa_q, wa_d;
    logic [WIDTH-1:0] wb_q, wb_d;

    logic [SUM_W-1:0] diff;
    logic             mis;

    assign op_vec = (state_q == RUN) ? cnt_q : '0;
    assign op_a   = op_vec[VW-1:WIDTH];
    assign op_b   = op_vec[WIDTH-1:0];

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign err_count   = err_q;
    assign max_abs_err = max_q;
    assign sum_abs_err = acc_q;
    assign worst_a     = wa_q;
    assign worst_b     = wb_q;

    adder_err_diff #(
        .SUM_W (SUM_W)
    ) u_diff (
        .exact_sum  (exact_sum),
        .approx_sum (approx_sum),
        .abs_diff   (diff),
        .mismatch   (mis)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s1_valid_d = (state_q == RUN) && !abort;
        s1_mis_d   = mis;
        s1_diff_d  = diff;
        s1_a_d     = op_a;
        s1_b_d     = op_b;
        err_d      = err_q;
        max_d      = max_q;
        acc_d      = acc_q;
        wa_d       = wa_q;
        wb_d       = wb_q;

        if (s1_valid_q) begin
            err_d = err_q + CNT_W'(s1_mis_q);
            acc_d = acc_q + ACC_W'(s1_diff_q);
            // strict compare keeps the earliest vector on ties
            if (s1_diff_q > max_q) begin
                max_d = s1_diff_q;
                wa_d  = s1_a_q;
                wb_d  = s1_b_q;
            end
        end

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        s1_valid_d = 1'b0;
                        err_d      = '0;
                        max_d      = '0;
                        acc_d      = '0;
                        wa_d       = '0;
                        wb_d       = '0;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + VW'(1);
                    if (cnt_q == '1) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_mis_q   <= 1'b0;
            s1_diff_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            err_q      <= '0;
            max_q      <= '0;
            acc_q      <= '0;
            wa_q       <= '0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_mis_q   <= s1_mis_d;
            s1_diff_q  <= s1_diff_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            err_q      <= err_d;
            max_q      <= max_d;
            acc_q      <= acc_d;
            wa_q       <= wa_d;
            wb_q       <= wb_d;
        end
    end

endmodule

// File: tb/tb_adder_err_eval_seq.sv
// Bench for adder_err_eval_seq: two WIDTH=8 instances swept in parallel
// and one WIDTH=2 instance with selectable approximate-adder behaviour.
module tb_adder_err_eval_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst_n, rst2_n;
    logic start8, start2, abort8, abort2;

    logic [7:0]  a8a, b8a, a8b, b8b, wa8a, wb8a, wa8b, wb8b;
    logic [8:0]  ex8a, ap8a, ex8b, ap8b, mx8a, mx8b;
    logic [16:0] ec8a, ec8b;
    logic [24:0] sa8a, sa8b;
    logic        busy8a, done8a, busy8b, done8b;

    logic [1:0]  a2, b2, wa2, wb2;
    logic [2:0]  ex2, ap2, mx2;
    logic [4:0]  ec2;
    logic [6:0]  sa2;
    logic        busy2, done2;

    int          mode2;
    logic [2:0]  lut [16];

    assign ex8a = {1'b0, a8a} + {1'b0, b8a};
    assign ap8a = ex8a;
    assign ex8b = {1'b0, a8b} + {1'b0, b8b};
    assign ap8b = {ex8b[8:1], 1'b0};
    assign ex2  = {1'b0, a2} + {1'b0, b2};

    always_comb begin
        ap2 = ex2;
        case (mode2)
            1:       ap2 = {1'b0, ex2[1:0]};
            2:       ap2 = lut[{a2, b2}];
            default: ap2 = ex2;
        endcase
    end

    adder_err_eval_seq #(.WIDTH(8)) u8a (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .op_a(a8a), .op_b(b8a), .exact_sum(ex8a), .approx_sum(ap8a),
        .busy(busy8a), .done(done8a), .err_count(ec8a),
        .max_abs_err(mx8a), .sum_abs_err(sa8a),
        .worst_a(wa8a), .worst_b(wb8a)
    );

    adder_err_eval_seq #(.WIDTH(8)) u8b (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .op_a(a8b), .op_b(b8b), .exact_sum(ex8b), .approx_sum(ap8b),
        .busy(busy8b), .done(done8b), .err_count(ec8b),
        .max_abs_err(mx8b), .sum_abs_err(sa8b),
        .worst_a(wa8b), .worst_b(wb8b)
    );

    adder_err_eval_seq #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .abort(abort2),
        .op_a(a2), .op_b(b2), .exact_sum(ex2), .approx_sum(ap2),
        .busy(busy2), .done(done2), .err_count(ec2),
        .max_abs_err(mx2), .sum_abs_err(sa2),
        .worst_a(wa2), .worst_b(wb2)
    );

    // Reference: m=0 exact, 1 drop sum MSB, 2 lookup table, 3 drop LSB
    function automatic int approx_of(int w, int m, int a, int b);
        int s;
        s = a + b;
        case (m)
            1:       return s % (1 << w);
            2:       return int'(lut[a * 4 + b]);
            3:       return s - (s % 2);
            default: return s;
        endcase
    endfunction

    task automatic model(input int w, input int m, output int cnt,
                         output int mx, output int sum,
                         output int wa, output int wb);
        int s, p, d;
        cnt = 0; mx = 0; sum = 0; wa = 0; wb = 0;
        for (int a = 0; a < (1 << w); a++) begin
            for (int b = 0; b < (1 << w); b++) begin
                s = a + b;
                p = approx_of(w, m, a, b);
                d = (s > p) ? s - p : p - s;
                if (d != 0) cnt++;
                sum += d;
                if (d > mx) begin
                    mx = d; wa = a; wb = b;
                end
            end
        end
    endtask

    task automatic new_lut();
        for (int i = 0; i < 16; i++) lut[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic sweep2(input bit repulse, output int done_cyc,
                          output int busy_n, output int op_bad);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        done_cyc = -1; busy_n = 0; op_bad = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (busy2) busy_n++;
            if (cyc <= 16 && {a2, b2} !== 4'(cyc - 1)) op_bad++;
            if (cyc > 16 && {a2, b2} !== 4'd0) op_bad++;
            if (done2) begin
                done_cyc = cyc;
                break;
            end
            start2 = repulse && (cyc == 4 || cyc == 10);
            @(negedge clk);
        end
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({busy8a, done8a, ec8a, mx8a, sa8a, wa8a, wb8a, a8a, b8a} !== '0) begin
            bad++;
            $display("FAIL reset8: busy=%0d done=%0d err=%0d max=%0d want all 0",
                     busy8a, done8a, ec8a, mx8a);
        end
        total++;
        if ({busy2, done2, ec2, mx2, sa2, wa2, wb2, a2, b2} !== '0) begin
            bad++;
            $display("FAIL reset2: busy=%0d done=%0d err=%0d max=%0d want all 0",
                     busy2, done2, ec2, mx2);
        end
    endtask

    task automatic test_w8_sweep();
        int e0c, e0m, e0s, e0a, e0b, e1c, e1m, e1s, e1a, e1b;
        int done_cyc, busy_n;
        model(8, 0, e0c, e0m, e0s, e0a, e0b);
        model(8, 3, e1c, e1m, e1s, e1a, e1b);
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        done_cyc = -1; busy_n = 0;
        for (int cyc = 1; cyc <= 65600; cyc++) begin
            if (busy8a) busy_n++;
            if (done8a) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (done_cyc != 65538) begin
            bad++;
            $display("FAIL w8_done_cycle: got %0d want 65538", done_cyc);
        end
        total++;
        if (busy_n != 65537) begin
            bad++;
            $display("FAIL w8_busy_cycles: got %0d want 65537", busy_n);
        end
        total++;
        if (done8b !== 1'b1) begin
            bad++;
            $display("FAIL w8b_done: got %0d want 1", done8b);
        end
        total++;
        if (ec8a !== 17'(e0c) || mx8a !== 9'(e0m) || sa8a !== 25'(e0s) ||
            wa8a !== 8'(e0a) || wb8a !== 8'(e0b)) begin
            bad++;
            $display("FAIL w8_exact: got err=%0d max=%0d sum=%0d wa=%0d wb=%0d want %0d %0d %0d %0d %0d",
                     ec8a, mx8a, sa8a, wa8a, wb8a, e0c, e0m, e0s, e0a, e0b);
        end
        total++;
        if (ec8b !== 17'(e1c) || mx8b !== 9'(e1m) || sa8b !== 25'(e1s) ||
            wa8b !== 8'(e1a) || wb8b !== 8'(e1b)) begin
            bad++;
            $display("FAIL w8_lsb0: got err=%0d max=%0d sum=%0d wa=%0d wb=%0d want %0d %0d %0d %0d %0d",
                     ec8b, mx8b, sa8b, wa8b, wb8b, e1c, e1m, e1s, e1a, e1b);
        end
        total++;
        if (ec8b !== 17'd32768 || mx8b !== 9'd1 || wb8b !== 8'd1) begin
            bad++;
            $display("FAIL w8_lsb0_plan: got err=%0d max=%0d wb=%0d want 32768 1 1",
                     ec8b, mx8b, wb8b);
        end
    endtask

    task automatic test_w2_msb();
        int ec, em, es, ea, eb, dc, bn, ob;
        mode2 = 1;
        model(2, 1, ec, em, es, ea, eb);
        sweep2(1'b0, dc, bn, ob);
        total++;
        if (dc != 18 || bn != 17 || ob != 0) begin
            bad++;
            $display("FAIL w2_timing: got done=%0d busy=%0d opbad=%0d want 18 17 0",
                     dc, bn, ob);
        end
        total++;
        if (ec2 !== 5'(ec) || mx2 !== 3'(em) || sa2 !== 7'(es) ||
            wa2 !== 2'(ea) || wb2 !== 2'(eb)) begin
            bad++;
            $display("FAIL w2_msb: got err=%0d max=%0d sum=%0d wa=%0d wb=%0d want %0d %0d %0d %0d %0d",
                     ec2, mx2, sa2, wa2, wb2, ec, em, es, ea, eb);
        end
    endtask

    task automatic test_w2_random();
        int ec, em, es, ea, eb, dc, bn, ob;
        mode2 = 2;
        for (int it = 0; it < 4; it++) begin
            new_lut();
            model(2, 2, ec, em, es, ea, eb);
            sweep2(1'b0, dc, bn, ob);
            total++;
            if (dc != 18 || ec2 !== 5'(ec) || mx2 !== 3'(em) ||
                sa2 !== 7'(es) || wa2 !== 2'(ea) || wb2 !== 2'(eb)) begin
                bad++;
                $display("FAIL w2_rand%0d: got done=%0d err=%0d max=%0d sum=%0d wa=%0d wb=%0d want 18 %0d %0d %0d %0d %0d",
                         it, dc, ec2, mx2, sa2, wa2, wb2, ec, em, es, ea, eb);
            end
        end
    endtask

    task automatic test_abort();
        int ec, em, es, ea, eb, dc, bn, ob;
        bit hit;
        mode2 = 1;
        model(2, 1, ec, em, es, ea, eb);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ({a2, b2} == 4'd5) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL abort_reach5: got no vector 5 want vector 5");
        end
        abort2 = 1'b1;
        @(negedge clk) abort2 = 1'b0;
        total++;
        if ({busy2, done2, a2, b2} !== 6'd0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%0d done=%0d op=%0d want 0 0 0",
                     busy2, done2, {a2, b2});
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL abort_stay: got busy=%0d done=%0d want 0 0", busy2, done2);
        end
        sweep2(1'b0, dc, bn, ob);
        total++;
        if (dc != 18 || ec2 !== 5'(ec) || mx2 !== 3'(em) || sa2 !== 7'(es) ||
            wa2 !== 2'(ea) || wb2 !== 2'(eb)) begin
            bad++;
            $display("FAIL abort_rerun: got done=%0d err=%0d max=%0d sum=%0d want 18 %0d %0d %0d",
                     dc, ec2, mx2, sa2, ec, em, es);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bn, ob;
        mode2 = 0;
        sweep2(1'b1, dc, bn, ob);
        total++;
        if (dc != 18 || bn != 17 || ob != 0) begin
            bad++;
            $display("FAIL repulse: got done=%0d busy=%0d opbad=%0d want 18 17 0",
                     dc, bn, ob);
        end
        @(negedge clk) begin
            start2 = 1'b1;
            abort2 = 1'b1;
        end
        @(negedge clk) begin
            start2 = 1'b0;
            abort2 = 1'b0;
        end
        total++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL start_abort: got busy=%0d done=%0d want 0 0", busy2, done2);
        end
        @(negedge clk);
        total++;
        if (busy2 !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_hold: got busy=%0d want 0", busy2);
        end
    endtask

    task automatic test_rst_mid();
        int ec, em, es, ea, eb, dc, bn, ob;
        bit hit;
        mode2 = 2;
        new_lut();
        model(2, 2, ec, em, es, ea, eb);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ({a2, b2} == 4'd9) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_reach9: got no vector 9 want vector 9");
        end
        rst2_n = 1'b0;
        #1;
        total++;
        if ({busy2, done2, ec2, mx2, sa2, wa2, wb2, a2, b2} !== '0) begin
            bad++;
            $display("FAIL rst_async: got busy=%0d err=%0d sum=%0d op=%0d want all 0",
                     busy2, ec2, sa2, {a2, b2});
        end
        @(negedge clk) rst2_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || sa2 !== 7'd0) begin
            bad++;
            $display("FAIL rst_idle: got busy=%0d done=%0d sum=%0d want 0 0 0",
                     busy2, done2, sa2);
        end
        sweep2(1'b0, dc, bn, ob);
        total++;
        if (dc != 18 || ec2 !== 5'(ec) || mx2 !== 3'(em) || sa2 !== 7'(es) ||
            wa2 !== 2'(ea) || wb2 !== 2'(eb)) begin
            bad++;
            $display("FAIL rst_rerun: got done=%0d err=%0d max=%0d sum=%0d want 18 %0d %0d %0d",
                     dc, ec2, mx2, sa2, ec, em, es);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        start8 = 1'b0; start2 = 1'b0;
        abort8 = 1'b0; abort2 = 1'b0;
        mode2 = 0;
        for (int i = 0; i < 16; i++) lut[i] = 3'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        test_w8_sweep();
        test_w2_msb();
        test_w2_random();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
